// File: rtl/aes_key_expand_if.sv
// Handshake and key-bank bundle between the key loader and aes_key_expand.
// Latency: none, wires only.
// Backpressure: key_ready low while an expansion runs; key_valid is not queued.
// Signals: key_valid/key_ready/key_in (load side), keys_valid/busy/round_keys
// (bank side), zeroize only when AES_KEY_ZEROIZE_EN is defined.
// master = key source / round pipeline side, slave = aes_key_expand.
interface aes_key_expand_if #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
);
`ifdef AES_KEY_ZEROIZE_EN
  logic                             zeroize;
`endif
  logic                             key_valid;
  logic                             key_ready;
  logic [KEY_W-1:0]                 key_in;
  logic                             keys_valid;
  logic                             busy;
  logic [KEY_W*(NUM_ROUNDS+1)-1:0]  round_keys;

  modport master (
`ifdef AES_KEY_ZEROIZE_EN
    output zeroize,
`endif
    output key_valid,
    output key_in,
    input  key_ready,
    input  keys_valid,
    input  busy,
    input  round_keys
  );

  modport slave (
`ifdef AES_KEY_ZEROIZE_EN
    input  zeroize,
`endif
    input  key_valid,
    input  key_in,
    output key_ready,
    output keys_valid,
    output busy,
    output round_keys
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank.
// Latency: keys_valid rises 10 edges after the edge that accepts a key.
// Backpressure: key_ready=0 during expansion; key_valid then is dropped, not queued.
// Ports: clk, rst (async, active-high); kif (slave) carries key_valid/key_ready/
// key_in, keys_valid, busy and the flat round_keys bank (rk[i] at [128*i +: 128]).
// Optional: AES_KEY_ZEROIZE_EN adds kif.zeroize, a one-cycle wipe of the bank.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic            clk,
  input  logic            rst,
  aes_key_expand_if.slave kif
);

  if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_param_check
    $error("aes_key_expand: only AES-128 (NUM_ROUNDS=10, KEY_W=128) is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // Forward S-box, entry 0 first; stored [255:0] so entry x sits at index ~x.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[~x];
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  state_t                          state_q, state_d;
  logic [3:0]                      rnd_q, rnd_d;
  logic [7:0]                      rcon_q, rcon_d;
  logic [NUM_ROUNDS:0][KEY_W-1:0]  bank_q, bank_d;

  logic             zeroize;
  logic             accept;
  logic [KEY_W-1:0] prev_key;
  logic [31:0]      temp, w0_n, w1_n, w2_n, w3_n;

`ifdef AES_KEY_ZEROIZE_EN
  assign zeroize = kif.zeroize;
`else
  assign zeroize = 1'b0;
`endif

  // Zeroize wins over a simultaneous key accept.
  assign accept = kif.key_valid && (state_q != ST_EXPAND) && !zeroize;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (kif.key_valid) state_d = ST_EXPAND;
        ST_EXPAND: if (rnd_q == LAST_RND) state_d = ST_DONE;
        ST_DONE:   if (kif.key_valid) state_d = ST_EXPAND;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    kif.key_ready  = (state_q != ST_EXPAND);
    kif.busy       = (state_q == ST_EXPAND);
    kif.keys_valid = (state_q == ST_DONE);
  end

  assign kif.round_keys = bank_q;

  // One key-schedule round: rk[rnd] from rk[rnd-1]. rnd_q is 1..10 in EXPAND.
  always_comb begin
    prev_key = bank_q[rnd_q - 4'd1];
    temp     = {sbox(prev_key[23:16]), sbox(prev_key[15:8]),
                sbox(prev_key[7:0]),   sbox(prev_key[31:24])} ^ {rcon_q, 24'h0};
    w0_n     = prev_key[127:96] ^ temp;
    w1_n     = prev_key[95:64]  ^ w0_n;
    w2_n     = prev_key[63:32]  ^ w1_n;
    w3_n     = prev_key[31:0]   ^ w2_n;
  end

  always_comb begin
    bank_d = bank_q;
    rnd_d  = rnd_q;
    rcon_d = rcon_q;
    if (zeroize) begin
      bank_d = '0;
      rnd_d  = 4'd0;
      rcon_d = 8'h01;
    end else if (accept) begin
      // Upper slices keep stale data until overwritten; keys_valid guards them.
      bank_d[0] = kif.key_in;
      rnd_d     = 4'd1;
      rcon_d    = 8'h01;
    end else if (state_q == ST_EXPAND) begin
      bank_d[rnd_q] = {w0_n, w1_n, w2_n, w3_n};
      rnd_d         = (rnd_q == LAST_RND) ? 4'd0 : rnd_q + 4'd1;
      rcon_d        = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
      rnd_q  <= 4'd0;
      rcon_q <= 8'h01;
    end else begin
      bank_q <= bank_d;
      rnd_q  <= rnd_d;
      rcon_q <= rcon_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: GF(2^8)-derived S-box and word-chain key schedule
// model, per-cycle output compare, plus literal FIPS-197 vectors.
module tb_aes_key_expand;

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K_OTHER  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst;

  aes_key_expand_if #(.NUM_ROUNDS(10), .KEY_W(128)) kif();

  aes_key_expand #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0]       w [44];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [10:0][127:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // age: -1 = nothing held; otherwise edges since the accepting edge, capped at 10.
  int                 age = -1;
  logic [10:0][127:0] m_sched = '0;

  initial begin
    logic zero_req;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        age = -1;
      end else begin
        zero_req = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
        zero_req = kif.zeroize;
`endif
        if (zero_req) age = -1;
        else if (kif.key_valid && !(age >= 0 && age < 10)) begin
          m_sched = expand(kif.key_in);
          age = 0;
        end else if (age >= 0 && age < 10) age++;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic exp_busy;
    forever begin
      @(negedge clk);
      exp_busy = (age >= 0 && age < 10);
      chk("cyc_key_ready",  128'(kif.key_ready),  128'(!exp_busy));
      chk("cyc_busy",       128'(kif.busy),       128'(exp_busy));
      chk("cyc_keys_valid", 128'(kif.keys_valid), 128'(age >= 10));
      for (int i = 0; i <= 10; i++) begin
        if (age < 0)
          chk($sformatf("cyc_rk%0d_clear", i), kif.round_keys[128*i +: 128], 128'h0);
        else if (i <= age)
          chk($sformatf("cyc_rk%0d", i), kif.round_keys[128*i +: 128], m_sched[i]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k);
    kif.key_valid = 1'b1;
    kif.key_in    = k;
    tick();
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      lat++;
      if (kif.keys_valid) break;
    end
    if (!kif.keys_valid) chk("wait_valid_timeout", 128'(kif.keys_valid), 128'h1);
  endtask

  function automatic logic [127:0] rk(input int i);
    return kif.round_keys[128*i +: 128];
  endfunction

  initial begin
    int lat;
    int nb;
    int nv;
    logic [7:0] inv, b;
    logic [10:0][127:0] pin;

    rst           = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_in    = '0;
`ifdef AES_KEY_ZEROIZE_EN
    kif.zeroize   = 1'b0;
`endif

    // S-box from the multiplicative inverse and affine map.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    // Pin the model to published vectors.
    pin = expand(K_FIPS);
    chk("model_fips_rk1", pin[1], FIPS_RK1);
    chk("model_fips_rk10", pin[10], FIPS_R10);
    pin = expand(128'h0);
    chk("model_zero_rk1", pin[1], ZERO_RK1);
    chk("model_zero_rk10", pin[10], ZERO_R10);

    // Reset state
    repeat (3) tick();
    chk("rst_key_ready",  128'(kif.key_ready),   128'h1);
    chk("rst_keys_valid", 128'(kif.keys_valid),  128'h0);
    chk("rst_busy",       128'(kif.busy),        128'h0);
    chk("rst_round_keys", 128'(|kif.round_keys), 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 key from IDLE
    send_key(K_FIPS);
    wait_valid(lat);
    chk("fips_latency", 128'(lat), 128'd10);
    chk("fips_rk0", rk(0), K_FIPS);
    chk("fips_rk1", rk(1), FIPS_RK1);
    chk("fips_rk10", rk(10), FIPS_R10);
    repeat (3) tick();

    // New (all-zero) key accepted in DONE
    send_key(128'h0);
    chk("done_reload_keys_valid", 128'(kif.keys_valid), 128'h0);
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      if (kif.busy) nb++;
      tick();
      if (kif.keys_valid) break;
    end
    chk("zero_busy_cycles", 128'(nb), 128'd10);
    chk("zero_rk1", rk(1), ZERO_RK1);
    chk("zero_rk10", rk(10), ZERO_R10);

    // Key pulsed at cycle 4 of EXPAND is ignored
    send_key(K_FIPS);
    repeat (3) tick();
    kif.key_valid = 1'b1;
    kif.key_in    = K_OTHER;
    chk("ignore_key_ready", 128'(kif.key_ready), 128'h0);
    tick();
    kif.key_valid = 1'b0;
    wait_valid(lat);
    chk("ignore_rk0", rk(0), K_FIPS);
    chk("ignore_rk10", rk(10), FIPS_R10);

    // Asynchronous reset in round 6
    send_key(K_FIPS);
    repeat (5) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_round_keys", 128'(|kif.round_keys), 128'h0);
    chk("arst_key_ready",  128'(kif.key_ready),   128'h1);
    chk("arst_keys_valid", 128'(kif.keys_valid),  128'h0);
    chk("arst_busy",       128'(kif.busy),        128'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    send_key(128'h0);
    wait_valid(lat);
    chk("post_rst_latency", 128'(lat), 128'd10);
    chk("post_rst_rk10", rk(10), ZERO_R10);

    // key_valid held through DONE: immediate restart, one-cycle keys_valid
    kif.key_valid = 1'b1;
    kif.key_in    = K_FIPS;
    tick();
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (kif.keys_valid) nv++;
    end
    kif.key_valid = 1'b0;
    chk("b2b_valid_cycles", 128'(nv), 128'd1);
    wait_valid(lat);
    chk("b2b_rk10", rk(10), FIPS_R10);

`ifdef AES_KEY_ZEROIZE_EN
    kif.zeroize = 1'b1;
    tick();
    kif.zeroize = 1'b0;
    chk("zeroize_round_keys", 128'(|kif.round_keys), 128'h0);
    chk("zeroize_keys_valid", 128'(kif.keys_valid),  128'h0);
    chk("zeroize_key_ready",  128'(kif.key_ready),   128'h1);
    kif.zeroize   = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_in    = K_FIPS;
    tick();
    kif.zeroize   = 1'b0;
    kif.key_valid = 1'b0;
    chk("zeroize_drop_busy", 128'(kif.busy), 128'h0);
    chk("zeroize_drop_rk0",  rk(0),          128'h0);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
